// File: rtl/march_sequencer.sv
// march_sequencer: march-algorithm sequencer driving the PMBIST address counter
//
// Walks up to MAX_ELEM programmable march elements. For each element it loads
// the address counter (s_out for up, r_out for down) and then issues the
// element's 1..4 read/write ops per address over an op_valid/op_ready handshake.
// hold_out releases the counter only in the cycle the last op of a visit is
// accepted, so the counter advances exactly once per visit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse that begins a run (ignored while busy)
//   admd_in, num_elem   address mode and element count-1, sampled on start
//   cfg_we/addr/data    element-table write port (ignored while busy)
//   op_ready            memory stage accepts the current op
//   admd_out, updwn_out, s_out, r_out, hold_out   address counter controls
//   op_valid, op_we, op_pol                        op to the memory stage
//   elem_idx, busy, done                           run status
//
// Element word: [11] pause, [10] dir (1=down), [9:8] nops-1, [7:0] ops {we,pol}.
// Optional macro MARCH_PAUSE_EN: elements with bit 11 set are preceded by a
// PAUSE_CYCLES-long retention pause. Without it bit 11 is stored but ignored.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef ADMD_LIUD
`define ADMD_LIUD 1'b0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 1'b1
`endif

module march_sequencer #(
    parameter int ADDR_WIDTH   = `ADDR_WIDTH,
    parameter int MAX_ELEM     = 8,
    parameter int PAUSE_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        admd_in,
    input  logic [$clog2(MAX_ELEM)-1:0] num_elem,
    input  logic                        cfg_we,
    input  logic [$clog2(MAX_ELEM)-1:0] cfg_addr,
    input  logic [11:0]                 cfg_data,
    input  logic                        op_ready,
    output logic                        admd_out,
    output logic                        updwn_out,
    output logic                        s_out,
    output logic                        r_out,
    output logic                        hold_out,
    output logic                        op_valid,
    output logic                        op_we,
    output logic                        op_pol,
    output logic [$clog2(MAX_ELEM)-1:0] elem_idx,
    output logic                        busy,
    output logic                        done
);
    localparam int EW = $clog2(MAX_ELEM);
    localparam int VW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, OPS, NEXT, DONE
`ifdef MARCH_PAUSE_EN
        , PAUSE
`endif
    } state_t;

    logic [11:0] tbl [MAX_ELEM];

    state_t        state_q, state_d;
    logic [EW-1:0] idx_q, idx_d;
    logic [EW-1:0] num_q, num_d;
    logic          admd_q, admd_d;
    logic [11:0]   cur_q, cur_d;
    logic [1:0]    opi_q, opi_d;
    logic [VW-1:0] vis_q, vis_d;
    logic          updwn_q, updwn_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          op_valid_q, op_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          enter, setup;
    logic          last_op;
    logic [VW-1:0] v_last;

`ifdef MARCH_PAUSE_EN
    localparam int PW = $clog2(PAUSE_CYCLES + 1);
    logic [PW-1:0] cnt_q, cnt_d;
`else
    logic unused_pause;
    assign unused_pause = cur_q[11];
`endif

    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) tbl[cfg_addr] <= cfg_data;
    end

    // PRUD visits one address fewer because the LFSR never produces zero
    assign v_last  = {1'b0, {ADDR_WIDTH{1'b1}}} - {{ADDR_WIDTH{1'b0}}, admd_q == `ADMD_PRUD};
    assign last_op = opi_q == cur_q[9:8];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        admd_d     = admd_q;
        cur_d      = cur_q;
        opi_d      = opi_q;
        vis_d      = vis_q;
        updwn_d    = updwn_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        op_valid_d = op_valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        enter      = 1'b0;
        setup      = 1'b0;
`ifdef MARCH_PAUSE_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    idx_d  = '0;
                    admd_d = admd_in;
                    num_d  = num_elem;
                    enter  = 1'b1;
                end
            end
            SETUP: begin
                state_d    = OPS;
                op_valid_d = 1'b1;
            end
            OPS: begin
                if (op_ready) begin
                    opi_d = last_op ? 2'd0 : opi_q + 2'd1;
                    vis_d = last_op ? vis_q + VW'(1) : vis_q;
                    if (last_op && vis_q == v_last) begin
                        state_d    = NEXT;
                        op_valid_d = 1'b0;
                    end
                end
            end
            NEXT: begin
                if (idx_q == num_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + EW'(1);
                    enter = 1'b1;
                end
            end
`ifdef MARCH_PAUSE_EN
            PAUSE: begin
                cnt_d = cnt_q - PW'(1);
                setup = cnt_q == PW'(1);
            end
`endif
            default: state_d = IDLE;
        endcase
        // Entering an element: latch its word, then pause or go straight to SETUP
        if (enter) begin
            cur_d = tbl[idx_d];
`ifdef MARCH_PAUSE_EN
            if (cur_d[11]) begin
                state_d = PAUSE;
                cnt_d   = PW'(PAUSE_CYCLES);
            end else begin
                setup = 1'b1;
            end
`else
            setup = 1'b1;
`endif
        end
        if (setup) begin
            state_d = SETUP;
            s_d     = !cur_d[10];
            r_d     = cur_d[10];
            updwn_d = cur_d[10];
            opi_d   = 2'd0;
            vis_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            admd_q     <= 1'b0;
            cur_q      <= '0;
            opi_q      <= '0;
            vis_q      <= '0;
            updwn_q    <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MARCH_PAUSE_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            admd_q     <= admd_d;
            cur_q      <= cur_d;
            opi_q      <= opi_d;
            vis_q      <= vis_d;
            updwn_q    <= updwn_d;
            s_q        <= s_d;
            r_q        <= r_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MARCH_PAUSE_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign admd_out  = admd_q;
    assign updwn_out = updwn_q;
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign op_valid  = op_valid_q;
    assign op_we     = cur_q[{1'b0, opi_q, 1'b1}];
    assign op_pol    = cur_q[{1'b0, opi_q, 1'b0}];
    assign elem_idx  = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    // Counter runs while loading in SETUP and on acceptance of a visit's last op
    assign hold_out  = !(state_q == SETUP || (state_q == OPS && op_ready && last_op));

endmodule

// File: tb/tb_march_sequencer.sv
// tb_march_sequencer: randomized self-checking bench for march_sequencer
module tb_march_sequencer;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst, start, admd_in, cfg_we, op_ready;
    logic [2:0]  num_elem, cfg_addr, elem_idx;
    logic [11:0] cfg_data;
    logic        admd_out, updwn_out, s_out, r_out, hold_out;
    logic        op_valid, op_we, op_pol, busy, done;

    march_sequencer #(.ADDR_WIDTH(AW), .MAX_ELEM(8), .PAUSE_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .admd_in(admd_in), .num_elem(num_elem),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .op_ready(op_ready),
        .admd_out(admd_out), .updwn_out(updwn_out), .s_out(s_out), .r_out(r_out),
        .hold_out(hold_out), .op_valid(op_valid), .op_we(op_we), .op_pol(op_pol),
        .elem_idx(elem_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit [2:0] e;
        bit       we;
        bit       pol;
        bit       last;
    } op_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    bit   [11:0] tbl [8];
    op_t         q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit [11:0] mk(input bit dir, input int n, input bit [7:0] ops);
        return {1'b0, dir, 2'(n - 1), ops};
    endfunction

    task automatic wr(input bit [2:0] a, input bit [11:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
        tbl[a]   = d;
    endtask

    // Reference: expand the table into the full ordered op list, then follow the DUT
    task automatic run(input bit admd, input bit [2:0] num, input int stall_pct, input bit poke);
        int stalls = 0;
        int ne = 0;
        int acc = 0;
        int v, nops, exp_ops;
        bit [11:0] w;
        q.delete();
        v = admd ? (1 << AW) - 1 : (1 << AW);
        for (int e = 0; e <= int'(num); e++) begin
            w = tbl[e];
            nops = int'(w[9:8]) + 1;
            for (int i = 0; i < v; i++)
                for (int k = 0; k < nops; k++)
                    q.push_back('{3'(e), w[2*k+1], w[2*k], k == nops - 1});
        end
        exp_ops  = q.size();
        admd_in  = admd;
        num_elem = num;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        admd_in  = ~admd;
        num_elem = ~num;
        cyc      = 1;
        while (!done && cyc < 20000) begin
            op_ready = $urandom_range(99) >= stall_pct;
            start    = poke && cyc == 40;
            cfg_we   = poke && cyc == 60;
            cfg_addr = 3'd0;
            cfg_data = ~tbl[0];
            #1;
            check("busy", busy, 1);
            check("admd_out", admd_out, admd);
            if (op_valid) begin
                if (q.size() == 0) begin
                    check("op_overrun", acc + 1, exp_ops);
                end else begin
                    check("op_we", op_we, q[0].we);
                    check("op_pol", op_pol, q[0].pol);
                    check("op_elem", elem_idx, q[0].e);
                    check("updwn", updwn_out, tbl[q[0].e][10]);
                    check("hold_ops", hold_out, !(op_ready && q[0].last));
                    if (op_ready) begin
                        void'(q.pop_front());
                        acc++;
                    end else begin
                        stalls++;
                    end
                end
            end else begin
                check("hold_gap", hold_out, !(s_out | r_out));
                if ((s_out | r_out) && ne < 8) begin
                    check("s_out", s_out, !tbl[ne][10]);
                    check("r_out", r_out, tbl[ne][10]);
                    check("setup_idx", elem_idx, ne);
                    ne++;
                end
            end
            tick();
        end
        start    = 1'b0;
        cfg_we   = 1'b0;
        op_ready = 1'b1;
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("done_cycle", cyc, 2 * (int'(num) + 1) + exp_ops + stalls + 1);
        check("ops", acc, exp_ops);
        check("elements", ne, int'(num) + 1);
        tick();
        check("done_hold", done, 1);
        check("hold_done", hold_out, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; admd_in = 1'b0; num_elem = 3'd0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 12'd0; op_ready = 1'b1;
        cyc = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hold", hold_out, 1);
        check("rst_valid", op_valid, 0);
        check("rst_sr", {s_out, r_out, updwn_out, admd_out}, 0);
        check("rst_idx", elem_idx, 0);

        // March C-: up W0, up R0W1, up R1W0, down R0W1, down R1W0, up R0
        wr(0, mk(0, 1, 8'h02));
        wr(1, mk(0, 2, 8'h0C));
        wr(2, mk(0, 2, 8'h09));
        wr(3, mk(1, 2, 8'h0C));
        wr(4, mk(1, 2, 8'h09));
        wr(5, mk(0, 1, 8'h00));
        run(0, 5, 0, 0);

        // rst mid-OPS at element 2, then rerun from element 0 with retained table
        admd_in = 1'b0; num_elem = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        while (!(op_valid && elem_idx == 3'd2) && cyc < 5000) tick();
        check("reach_e2", {op_valid, elem_idx}, {1'b1, 3'd2});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", op_valid, 0);
        check("mid_rst_hold", hold_out, 1);
        check("mid_rst_idx", elem_idx, 0);
        run(0, 5, 0, 0);

        wr(0, mk(0, 1, 8'h02));
        run(0, 0, 0, 0);
        wr(0, mk(0, 2, 8'h0C));
        run(1, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(3);
            for (int e = 0; e <= n; e++) wr(3'(e), 12'($urandom));
            run(1'($urandom), 3'(n), 25, r == 0);
            run(1'($urandom), 3'(n), 10, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
